fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
//   FETCH_XLEN    - datapath width the fetch-entry struct is laid out for
//   INST_BYTES    - fetch PC increment per instruction
//   fetch_entry_t - one prefetch buffer entry {pc, inst}
// fetch_unit instances with XLEN other than FETCH_XLEN need FETCH_XLEN updated here.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;
  localparam int unsigned INST_BYTES = 4;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO with synchronous flush, head shown combinationally.
// Ports:
//   clk   - clock, all state on rising edge
//   reset - synchronous active-high reset (empties the FIFO)
//   flush - synchronous flush, same effect as reset
//   push  - write wdata at the tail (caller guarantees space)
//   wdata - entry to write
//   pop   - drop the head entry (caller guarantees non-empty)
//   rdata - head entry
//   empty - FIFO holds no entries
//   count - current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    push,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    pop,
  output logic [WIDTH-1:0]        rdata,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q;
  logic [PtrW-1:0]  rptr_q;
  logic [CntW-1:0]  count_q;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      // Push and pop together leave occupancy unchanged, including when full.
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with a DEPTH-entry prefetch buffer and redirect support.
// Ports:
//   i_clk, i_reset              - clock and synchronous active-high reset
//   o_imem_req, o_imem_addr     - fetch request and its address
//   i_imem_rvld, i_imem_rdata   - response, exactly one cycle after the request
//   i_redirect, i_redirect_pc   - flush buffer and restart fetch at i_redirect_pc
//   o_inst_vld, o_inst, o_inst_pc, i_inst_rdy - buffer head handshake to decode
//   o_pc_debug, o_insn_vld      - registered trace of the last accepted instruction
// Build option: define FETCH_DEBUG_EN to implement the trace registers; otherwise the trace
// outputs are tied to zero.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = FETCH_XLEN,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_rvld,
  input  logic [XLEN-1:0] i_imem_rdata,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_inst_vld,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_inst_pc,
  input  logic            i_inst_rdy,
  output logic [XLEN-1:0] o_pc_debug,
  output logic            o_insn_vld
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] inflight_pc_q;
  logic            inflight_q;

  logic [CntW-1:0] fifo_count;
  logic [CntW-1:0] credit;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  fetch_entry_t                      wr_entry;
  fetch_entry_t                      head;
  logic [$bits(fetch_entry_t)-1:0]   head_bits;

  // Credit counts buffered entries plus the response still owed, so every in-flight
  // response is guaranteed a free slot when it lands.
  assign credit      = fifo_count + CntW'(inflight_q);
  assign o_imem_req  = !i_reset && !i_redirect && (credit < CntW'(DEPTH));
  assign o_imem_addr = fetch_pc_q;

  // A response is only accepted against an outstanding request; redirect and reset
  // clear the in-flight flag so the response after them is dropped.
  assign push = inflight_q && i_imem_rvld;
  assign pop  = o_inst_vld && i_inst_rdy;

  assign wr_entry = '{pc: inflight_pc_q, inst: i_imem_rdata};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (i_redirect) begin
      fetch_pc_q <= i_redirect_pc;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= o_imem_req;
      if (o_imem_req) begin
        inflight_pc_q <= fetch_pc_q;
        fetch_pc_q    <= fetch_pc_q + XLEN'(INST_BYTES);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (i_clk),
    .reset (i_reset),
    .flush (i_redirect),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head_bits),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head = head_bits;

  // Hide the head while in reset; the flush only takes effect at the edge.
  assign o_inst_vld = !fifo_empty && !i_reset;
  assign o_inst     = head.inst;
  assign o_inst_pc  = head.pc;

`ifdef FETCH_DEBUG_EN
  logic [XLEN-1:0] pc_debug_q;
  logic            insn_vld_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_debug_q <= '0;
      insn_vld_q <= 1'b0;
    end else begin
      insn_vld_q <= pop;
      if (pop) begin
        pc_debug_q <= o_inst_pc;
      end
    end
  end

  assign o_pc_debug = pc_debug_q;
  assign o_insn_vld = insn_vld_q;
`else
  assign o_pc_debug = '0;
  assign o_insn_vld = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit (XLEN=32, DEPTH=4, RESET_PC=0).
// A one-cycle-latency memory echoes the request address as the instruction word.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_fetch_unit;

  logic        clk;
  logic        i_reset;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_rvld;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_inst_vld;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_inst_rdy;
  logic [31:0] o_pc_debug;
  logic        o_insn_vld;

  logic        mem_rvld;
  logic [31:0] mem_rdata;
  logic        stray;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_unit #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_rvld   (i_imem_rvld),
    .i_imem_rdata  (i_imem_rdata),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_inst_vld    (o_inst_vld),
    .o_inst        (o_inst),
    .o_inst_pc     (o_inst_pc),
    .i_inst_rdy    (i_inst_rdy),
    .o_pc_debug    (o_pc_debug),
    .o_insn_vld    (o_insn_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: answers every request exactly one cycle later with data = address.
  always @(posedge clk) begin
    mem_rvld  <= o_imem_req;
    mem_rdata <= o_imem_addr;
  end
  assign i_imem_rvld  = mem_rvld | stray;
  assign i_imem_rdata = mem_rdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset       = 1'b1;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'h0;
    i_inst_rdy    = 1'b0;
    stray         = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_redirect = 1'b0; i_redirect_pc = 32'h0; i_inst_rdy = 1'b1; stray = 1'b0;
    tick();
    tick();
    #1;
    n_cmp++;
    if (o_imem_req !== 1'b0 || o_inst_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b vld=%b, want req=0 vld=0", o_imem_req, o_inst_vld);
    end
    n_cmp++;
    if (o_pc_debug !== 32'h0 || o_insn_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_debug: got pc_debug=%h insn_vld=%b, want 0/0", o_pc_debug, o_insn_vld);
    end
    i_reset = 1'b0;
    #1;
    n_cmp++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0 || o_inst_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_req: got req=%b addr=%h vld=%b, want req=1 addr=0 vld=0",
               o_imem_req, o_imem_addr, o_inst_vld);
    end
    tick();
  endtask

  task automatic test_stream();
    do_reset();
    i_inst_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_cmp++;
      if (o_imem_req !== 1'b1 || o_imem_addr !== 32'(4 * k)) begin
        n_fail++;
        $display("FAIL stream_req[%0d]: got req=%b addr=%h, want req=1 addr=%h",
                 k, o_imem_req, o_imem_addr, 32'(4 * k));
      end
      n_cmp++;
      if (o_inst_vld !== (k >= 2)) begin
        n_fail++;
        $display("FAIL stream_vld[%0d]: got %b, want %b", k, o_inst_vld, (k >= 2));
      end
      if (k >= 2) begin
        n_cmp++;
        if (o_inst_pc !== 32'(4 * (k - 2)) || o_inst !== 32'(4 * (k - 2))) begin
          n_fail++;
          $display("FAIL stream_head[%0d]: got pc=%h inst=%h, want %h/%h",
                   k, o_inst_pc, o_inst, 32'(4 * (k - 2)), 32'(4 * (k - 2)));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    i_inst_rdy = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_cmp++;
      if (o_imem_req !== (k < 4) || ((k < 4) && o_imem_addr !== 32'(4 * k))) begin
        n_fail++;
        $display("FAIL bp_req[%0d]: got req=%b addr=%h, want req=%b addr=%h",
                 k, o_imem_req, o_imem_addr, (k < 4), 32'(4 * k));
      end
      tick();
    end
    i_inst_rdy = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      n_cmp++;
      if (o_inst_vld !== 1'b1 || o_inst_pc !== 32'(4 * j)) begin
        n_fail++;
        $display("FAIL bp_drain[%0d]: got vld=%b pc=%h, want vld=1 pc=%h",
                 j, o_inst_vld, o_inst_pc, 32'(4 * j));
      end
      if (j == 0) begin
        n_cmp++;
        if (o_imem_req !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_full_noreq: got req=%b, want 0", o_imem_req);
        end
      end
      if (j == 1) begin
        n_cmp++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h10) begin
          n_fail++;
          $display("FAIL bp_credit_req: got req=%b addr=%h, want req=1 addr=00000010",
                   o_imem_req, o_imem_addr);
        end
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    i_inst_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      tick();
    end
    // Three entries buffered, 0xC in flight and answering this cycle.
    i_redirect = 1'b1; i_redirect_pc = 32'h100;
    #1;
    n_cmp++;
    if (o_imem_req !== 1'b0 || o_inst_vld !== 1'b1 || o_inst_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL redir_cycle: got req=%b vld=%b pc=%h, want req=0 vld=1 pc=0",
               o_imem_req, o_inst_vld, o_inst_pc);
    end
    tick();
    i_redirect = 1'b0; stray = 1'b1;
    #1;
    n_cmp++;
    if (o_inst_vld !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL redir_next: got vld=%b req=%b addr=%h, want vld=0 req=1 addr=00000100",
               o_inst_vld, o_imem_req, o_imem_addr);
    end
    tick();
    stray = 1'b0;
    #1;
    n_cmp++;
    if (o_inst_vld !== 1'b0 || o_imem_addr !== 32'h104) begin
      n_fail++;
      $display("FAIL redir_drop: got vld=%b addr=%h, want vld=0 addr=00000104",
               o_inst_vld, o_imem_addr);
    end
    tick();
    #1;
    n_cmp++;
    if (o_inst_vld !== 1'b1 || o_inst_pc !== 32'h100 || o_inst !== 32'h100) begin
      n_fail++;
      $display("FAIL redir_head: got vld=%b pc=%h inst=%h, want vld=1 pc/inst=00000100",
               o_inst_vld, o_inst_pc, o_inst);
    end
    // Two redirects on consecutive cycles: the second target wins.
    i_redirect = 1'b1; i_redirect_pc = 32'h200;
    tick();
    i_redirect_pc = 32'h300;
    #1;
    n_cmp++;
    if (o_imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_hold: got req=%b, want 0", o_imem_req);
    end
    tick();
    i_redirect = 1'b0;
    #1;
    n_cmp++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h300 || o_inst_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_req: got req=%b addr=%h vld=%b, want req=1 addr=00000300 vld=0",
               o_imem_req, o_imem_addr, o_inst_vld);
    end
    tick();
    tick();
    #1;
    n_cmp++;
    if (o_inst_vld !== 1'b1 || o_inst_pc !== 32'h300) begin
      n_fail++;
      $display("FAIL b2b_head: got vld=%b pc=%h, want vld=1 pc=00000300", o_inst_vld, o_inst_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    i_inst_rdy = 1'b1;
    i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
    tick();
    i_redirect = 1'b0;
    #1;
    n_cmp++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_req0: got req=%b addr=%h, want req=1 addr=fffffffc",
               o_imem_req, o_imem_addr);
    end
    tick();
    #1;
    n_cmp++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_req1: got req=%b addr=%h, want req=1 addr=00000000",
               o_imem_req, o_imem_addr);
    end
    tick();
    #1;
    n_cmp++;
    if (o_inst_vld !== 1'b1 || o_inst_pc !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_head0: got vld=%b pc=%h, want vld=1 pc=fffffffc", o_inst_vld, o_inst_pc);
    end
    tick();
    #1;
    n_cmp++;
    if (o_inst_vld !== 1'b1 || o_inst_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_head1: got vld=%b pc=%h, want vld=1 pc=0", o_inst_vld, o_inst_pc);
    end
    tick();
  endtask

  task automatic test_reset_full();
    do_reset();
    i_inst_rdy = 1'b0;
    i_redirect = 1'b1; i_redirect_pc = 32'h400;
    tick();
    i_redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      tick();
    end
    // Buffer holds 0x400..0x408 with 0x40C answering; a stale entry would carry 0x4xx.
    i_reset = 1'b1;
    #1;
    n_cmp++;
    if (o_imem_req !== 1'b0 || o_inst_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got req=%b vld=%b, want 0/0", o_imem_req, o_inst_vld);
    end
    tick();
    i_reset = 1'b0; i_inst_rdy = 1'b1;
    #1;
    n_cmp++;
    if (o_inst_vld !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_after: got vld=%b req=%b addr=%h, want vld=0 req=1 addr=0",
               o_inst_vld, o_imem_req, o_imem_addr);
    end
    tick();
    #1;
    n_cmp++;
    if (o_inst_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_gap: got vld=%b, want 0", o_inst_vld);
    end
    tick();
    for (int j = 0; j < 4; j++) begin
      #1;
      n_cmp++;
      if (o_inst_vld !== 1'b1 || o_inst_pc !== 32'(4 * j)) begin
        n_fail++;
        $display("FAIL rst_stream[%0d]: got vld=%b pc=%h, want vld=1 pc=%h",
                 j, o_inst_vld, o_inst_pc, 32'(4 * j));
      end
      tick();
    end
  endtask

  task automatic test_debug();
    logic [31:0] exp_pc;
    logic        exp_vld;
    do_reset();
    i_inst_rdy = 1'b1;
    for (int k = 0; k < 7; k++) begin
      #1;
`ifdef FETCH_DEBUG_EN
      // Pops start in cycle 2 with pc 0; the trace lags the pop by one cycle.
      exp_vld = (k >= 3);
      exp_pc  = (k >= 3) ? 32'(4 * (k - 3)) : 32'h0;
`else
      exp_vld = 1'b0;
      exp_pc  = 32'h0;
`endif
      n_cmp++;
      if (o_insn_vld !== exp_vld || o_pc_debug !== exp_pc) begin
        n_fail++;
        $display("FAIL debug[%0d]: got insn_vld=%b pc_debug=%h, want %b/%h",
                 k, o_insn_vld, o_pc_debug, exp_vld, exp_pc);
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    stray = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_full();
    test_debug();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
